// File: rtl/alu_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants for the multdiv path. Holds the FSM state
//                encodings, the Booth select codes and the iteration-count
//                helper used by the sequential multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Multiplier FSM state encodings
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Radix-4 Booth partial-product select codes
    localparam logic [2:0] c_ZERO = 3'd0;
    localparam logic [2:0] c_PM   = 3'd1;
    localparam logic [2:0] c_P2M  = 3'd2;
    localparam logic [2:0] c_NM   = 3'd3;
    localparam logic [2:0] c_N2M  = 3'd4;

    // MULT_ITERS: one radix-4 step retires two multiplier bits.
    function automatic int mult_iters(input int width);
        return width / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_recode.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : booth_recode
//  Description : Combinational radix-4 Booth recoder. Maps the window
//                {Q[1], Q[0], q-1} to a partial-product select code and an
//                invert/carry-in bit (set for the negative multiples).
//  Ports       : i_window  in  3  Booth window {Q[1], Q[0], q-1}
//                o_sel     out 3  select code (c_ZERO/c_PM/c_P2M/c_NM/c_N2M)
//                o_neg     out 1  invert the multiple and inject carry-in 1
//  Revision    : 1.0  initial release
// ============================================================================
module booth_recode
    import alu_pkg::*;
(
    input  logic [2:0] i_window,
    output logic [2:0] o_sel,
    output logic       o_neg
);

    always_comb begin
        o_sel = c_ZERO;
        o_neg = 1'b0;
        case (i_window)
            3'b001, 3'b010: o_sel = c_PM;
            3'b011:         o_sel = c_P2M;
            3'b100: begin
                o_sel = c_N2M;
                o_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                o_sel = c_NM;
                o_neg = 1'b1;
            end
            default: begin
                o_sel = c_ZERO;
                o_neg = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mult_booth.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : mult_booth
//  Description : Sequential WIDTH x WIDTH signed multiplier, radix-4 Booth.
//                One partial product per cycle through a WIDTH+2 bit adder
//                (the ALU carry-lookahead adder plus two sign bits), then an
//                arithmetic shift right by 2. Returns the low WIDTH product
//                bits with a one-cycle ready pulse.
//  Macro       : MULT_OVF_EN - when defined, data_exception flags a signed
//                product that does not fit in WIDTH bits; otherwise tied 0.
//  Ports       : clock           in   1      rising-edge clock
//                reset_n         in   1      asynchronous active-low reset
//                ctrl_MULT       in   1      start pulse (operands sampled)
//                data_operandA   in   WIDTH  multiplicand, two's complement
//                data_operandB   in   WIDTH  multiplier, two's complement
//                data_result     out  WIDTH  product[WIDTH-1:0], held
//                data_resultRDY  out  1      one-cycle result-valid pulse
//                data_exception  out  1      overflow, held with the result
//                busy            out  1      operation in flight
//  Revision    : 1.0  initial release
// ============================================================================
module mult_booth
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic             busy
);

    localparam int c_ITERS = mult_iters(WIDTH);
    localparam int c_CW    = $clog2(c_ITERS + 1);

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH+1:0] r_m;
    logic [WIDTH+1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [WIDTH-1:0] r_result;
    logic             r_rdy;
    logic             r_busy;

    logic [2:0]       w_sel;
    logic             w_neg;
    logic [WIDTH+1:0] w_mult;
    logic [WIDTH+1:0] w_addend;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH+1:0] w_acc_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_last;

    booth_recode u_recode (
        .i_window ({r_q[1:0], r_qm1}),
        .o_sel    (w_sel),
        .o_neg    (w_neg)
    );

    always_comb begin
        w_mult = '0;
        case (w_sel)
            c_PM, c_NM:   w_mult = r_m;
            c_P2M, c_N2M: w_mult = {r_m[WIDTH:0], 1'b0};
            default:      w_mult = '0;
        endcase
    end

    // Subtraction as ~X + 1: the recoder's negate bit is the adder carry-in.
    assign w_addend   = w_neg ? ~w_mult : w_mult;
    assign w_sum      = r_acc + w_addend + {{(WIDTH+1){1'b0}}, w_neg};
    // Arithmetic shift right by 2 of {sum, Q, q-1}; q-1 takes the old Q[1].
    assign w_acc_next = {{2{w_sum[WIDTH+1]}}, w_sum[WIDTH+1:2]};
    assign w_q_next   = {w_sum[1:0], r_q[WIDTH-1:2]};
    assign w_last     = (r_cnt == c_CW'(c_ITERS - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_m      <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_result <= '0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (ctrl_MULT) begin
                // Start from any state; in RUN this aborts the current op.
                r_state <= c_RUN;
                r_cnt   <= '0;
                r_m     <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
                r_acc   <= '0;
                r_q     <= data_operandB;
                r_qm1   <= 1'b0;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    c_RUN: begin
                        r_acc <= w_acc_next;
                        r_q   <= w_q_next;
                        r_qm1 <= r_q[1];
                        r_cnt <= r_cnt + c_CW'(1);
                        if (w_last) begin
                            r_state  <= c_DONE;
                            r_result <= w_q_next;
                            r_rdy    <= 1'b1;
                        end
                    end
                    c_DONE: begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MULT_OVF_EN
    logic             r_exc;
    logic [WIDTH:0]   w_top;
    logic             w_fin;

    // Product bits [2W-1:W-1] must all match the sign for a W-bit fit.
    assign w_top = {w_acc_next[WIDTH-1:0], w_q_next[WIDTH-1]};
    assign w_fin = (r_state == c_RUN) && !ctrl_MULT && w_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_exc <= 1'b0;
        end else if (w_fin) begin
            r_exc <= ~((&w_top) | ~(|w_top));
        end
    end

    assign data_exception = r_exc;
`else
    assign data_exception = 1'b0;
`endif

    assign data_result    = r_result;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mult_booth.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mult_booth
//  Description : Directed self-checking bench for mult_booth (WIDTH=32).
//                Expected products are hand-computed constants. Overflow
//                expectations follow MULT_OVF_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_booth;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        data_exception;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int n;
    int rdy_seen;

`ifdef MULT_OVF_EN
    localparam bit c_OVF = 1'b1;
`else
    localparam bit c_OVF = 1'b0;
`endif

    mult_booth #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .data_exception (data_exception),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive operands and a one-cycle start; returns #1 after the start edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
    endtask

    // Count edges after the start edge until RDY is seen (bounded).
    task automatic wait_rdy(output int edges);
        edges = 0;
        while (edges < 40) begin
            @(posedge clock);
            #1;
            edges++;
            if (data_resultRDY) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input bit exc);
        int e;
        start_op(a, b);
        check({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
        wait_rdy(e);
        check({tag, "_latency"}, e, 32'd16);
        check({tag, "_result"}, data_result, res);
        check({tag, "_exc"}, {31'b0, data_exception}, {31'b0, exc});
        check({tag, "_busy_rdy"}, {31'b0, busy}, 32'd1);
        @(posedge clock);
        #1;
        check({tag, "_rdy_pulse"}, {31'b0, data_resultRDY}, 32'd0);
        check({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
        check({tag, "_held"}, data_result, res);
    endtask

    initial begin
        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_result", data_result, 32'd0);
        check("rst_rdy", {31'b0, data_resultRDY}, 32'd0);
        check("rst_exc", {31'b0, data_exception}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("7x6",      32'd7,        32'd6,        32'd42,       1'b0);
        run_op("m5x3",     32'hFFFFFFFB, 32'd3,        32'hFFFFFFF1, 1'b0);
        run_op("max_x2",   32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, c_OVF);
        run_op("min_xm1",  32'h80000000, 32'hFFFFFFFF, 32'h80000000, c_OVF);
        run_op("min_x1",   32'h80000000, 32'd1,        32'h80000000, 1'b0);
        run_op("ffff_sq",  32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, c_OVF);
        run_op("max_sq",   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, c_OVF);
        run_op("zero",     32'd0,        32'h12345678, 32'd0,        1'b0);

        // Back-to-back: new start in the DONE cycle of the previous op.
        start_op(32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_rdy(n);
        check("b2b1_latency", n, 32'd16);
        check("b2b1_result", data_result, 32'd1);
        start_op(32'hFFFFFFF9, 32'hFFFFFFF7);
        check("b2b_busy_kept", {31'b0, busy}, 32'd1);
        check("b2b_rdy_clear", {31'b0, data_resultRDY}, 32'd0);
        wait_rdy(n);
        check("b2b2_latency", n, 32'd16);
        check("b2b2_result", data_result, 32'd63);
        check("b2b2_exc", {31'b0, data_exception}, 32'd0);
        repeat (2) @(posedge clock);
        #1;

        // Abort: restart with 4x5 at cycle 6, single RDY at cycle 23.
        start_op(32'd3, 32'd3);
        rdy_seen = 0;
        repeat (5) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_seen++;
        end
        check("abort_no_early_rdy", rdy_seen, 32'd0);
        start_op(32'd4, 32'd5);
        wait_rdy(n);
        check("abort_latency", n, 32'd16);
        check("abort_result", data_result, 32'd20);
        rdy_seen = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_seen++;
        end
        check("abort_single_rdy", rdy_seen, 32'd0);

        // Asynchronous reset mid-RUN.
        start_op(32'd9, 32'd9);
        repeat (7) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("async_rst_result", data_result, 32'd0);
        check("async_rst_rdy", {31'b0, data_resultRDY}, 32'd0);
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        check("async_rst_exc", {31'b0, data_exception}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        rdy_seen = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_seen++;
        end
        check("async_rst_no_rdy", rdy_seen, 32'd0);
        run_op("2x2_after_rst", 32'd2, 32'd2, 32'd4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_booth.md
# mult_booth

Sequential 32×32 signed multiplier for the processor's multdiv path. It uses radix-4 Booth recoding. Each cycle it adds one partial product through the ALU's 32-bit carry-lookahead adder, which is built from 8-bit CLA blocks, so one iteration fits the adder's single-cycle timing. It returns the low 32 bits of the product, a ready pulse and an overflow flag to the writeback/stall logic.

## Interface
- `WIDTH`, default 32: operand and result width. Must be even.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ctrl_MULT`  in  1  start pulse; operands are sampled on the same edge.
- `data_operandA`  in  WIDTH  multiplicand, two's complement.
- `data_operandB`  in  WIDTH  multiplier, two's complement.
- `data_result`  out  WIDTH  product bits [WIDTH-1:0], held until the next start.
- `data_resultRDY`  out  1  one-cycle pulse when `data_result` is valid.
- `data_exception`  out  1  overflow flag, valid with `data_resultRDY` and held with the result.
- `busy`  out  1  high from the start edge until the RDY cycle, inclusive.

## Operation
- Reset is asynchronous and active-low (`reset_n`). All outputs and state clear to 0 and the FSM goes to IDLE.
- FSM has three states:
  - IDLE → RUN on `ctrl_MULT`.
  - RUN → DONE when the iteration counter reaches WIDTH/2−1.
  - DONE → IDLE unconditionally, or → RUN if `ctrl_MULT` is high.
- Start loads the registers:
  - M ← A, sign-extended to WIDTH+2 bits.
  - Accumulator {ACC[WIDTH+1:0], Q[WIDTH-1:0], q₋₁} ← {0, B, 0}.
  - Counter ← 0.
- Each RUN cycle:
  - The triple {Q[1], Q[0], q₋₁} selects +0, +M, +2M, −M or −2M.
  - −X is computed as ~X plus carry-in 1 on the adder.
  - ACC ← ACC + selected multiple.
  - The whole accumulator then shifts right arithmetically by 2.
  - Counter increments.
- Completion: after WIDTH/2 iterations, product = {ACC[WIDTH-1:0], Q} (2·WIDTH bits).
  - `data_result` ← Q.
  - RDY pulses in the DONE cycle.
- Overflow: `data_exception` = 1 iff product bits [2·WIDTH-1:WIDTH-1] are not all equal, i.e. the signed result does not fit in WIDTH bits.
- A `ctrl_MULT` during RUN aborts the operation and restarts with the new operands. No RDY is emitted for the aborted operation.
- A `ctrl_MULT` in the DONE cycle starts a new operation back-to-back. RDY still pulses for the completed one.
- `data_result` and `data_exception` change only on a RDY cycle or on reset.
- Operands only need to be valid on the start edge.

## Timing
- Start edge = cycle 0. RUN covers cycles 1..WIDTH/2.
- RDY is high in cycle WIDTH/2+1, which is cycle 17 for the default width.
- Throughput is one multiply per WIDTH/2+1 cycles.
- `busy` rises the cycle after the start edge and falls after the RDY cycle.
- Adder path per cycle: Booth mux → 34-bit add → shift. No combinational path from inputs to outputs.
- If `reset_n` is asserted mid-RUN, outputs are 0 immediately (asynchronous). The first start after deassertion behaves normally.

## Configuration
- `MULT_OVF_EN` defined: the overflow detection logic above is built and `data_exception` reports overflow.
- `MULT_OVF_EN` undefined: no detection logic; `data_exception` is tied to 0.
- Product and RDY timing are identical either way.

## Structure
- Shared package `alu_pkg` holds:
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Booth select codes: ZERO, PM, P2M, NM, N2M.
  - `MULT_ITERS` = WIDTH/2.
- One sub-module, `booth_recode`: combinational. Maps the 3-bit window to a select code plus an invert/carry-in bit.
- The adder is the existing 32-bit CLA, extended by two sign bits in-line.

## Test plan
- 7 × 6 → result 42, exception 0, RDY in cycle 17.
- −5 × 3 → 0xFFFFFFF1, exception 0.
- 0x7FFFFFFF × 2 → 0xFFFFFFFE, exception 1 (0 when `MULT_OVF_EN` is undefined).
- 0x80000000 × −1 → 0x80000000, exception 1.
- 0x80000000 × 1 → 0x80000000, exception 0.
- Start 3 × 3, re-pulse `ctrl_MULT` with 4 × 5 at cycle 6 → a single RDY at cycle 23 (6+17) with result 20.
- Start 9 × 9, assert `reset_n` low at cycle 8 → outputs 0 immediately and no RDY. Then 2 × 2 after release → 4.
